// File: rtl/sd_block_pkg.sv
// Shared constants and state encoding for the SD block responder.
package sd_block_pkg;

    localparam int unsigned SD_BLOCK_BYTES = 512;
    localparam int unsigned SD_IDX_W       = 9;

    typedef enum logic [3:0] {
        StIdle,
        StRdReq,
        StRdWait,
        StRdPut,
        StWrAddr,
        StWrGet,
        StWrReq,
        StDone,
        StGap
    } sd_state_e;

endpackage

// File: rtl/sd_block_responder_if.sv
// Per-drive SD block bus plus the byte-wide backing-memory port.
// The slave modport is the responder's view; master is the initiator/memory side.
interface sd_block_responder_if #(
    parameter int unsigned MEM_AW = 27
);
    import sd_block_pkg::*;

    logic [31:0]          img_blocks;
    logic [31:0]          sd_lba;
    logic                 sd_rd;
    logic                 sd_wr;
    logic                 sd_ack;
    logic [SD_IDX_W-1:0]  sd_buff_addr;
    logic                 sd_buff_wr;
    logic [7:0]           sd_buff_dout;
    logic [7:0]           sd_buff_din;
    logic [MEM_AW-1:0]    mem_addr;
    logic                 mem_rd;
    logic                 mem_wr;
    logic [7:0]           mem_wdata;
    logic [7:0]           mem_rdata;
    logic                 mem_ready;

    modport slave (
        input  img_blocks, sd_lba, sd_rd, sd_wr, sd_buff_din, mem_rdata, mem_ready,
        output sd_ack, sd_buff_addr, sd_buff_wr, sd_buff_dout, mem_addr, mem_rd, mem_wr,
               mem_wdata
    );

    modport master (
        output img_blocks, sd_lba, sd_rd, sd_wr, sd_buff_din, mem_rdata, mem_ready,
        input  sd_ack, sd_buff_addr, sd_buff_wr, sd_buff_dout, mem_addr, mem_rd, mem_wr,
               mem_wdata
    );

endinterface

// File: rtl/sd_block_responder.sv
// Target side of the SD block protocol: serves one 512-byte block per sd_ack pulse,
// reading from / writing to a byte-wide backing memory.
module sd_block_responder
    import sd_block_pkg::*;
#(
    parameter int unsigned       MEM_AW      = 27,
    parameter logic [MEM_AW-1:0] MEM_BASE    = '0,
    parameter int unsigned       BUFF_RD_LAT = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    sd_block_responder_if.slave  bus
);

    localparam int unsigned         LAT_W    = (BUFF_RD_LAT > 1) ? $clog2(BUFF_RD_LAT) : 1;
    localparam logic [LAT_W-1:0]    LAT_LAST = LAT_W'(BUFF_RD_LAT - 1);
    localparam logic [SD_IDX_W-1:0] IDX_LAST = SD_IDX_W'(SD_BLOCK_BYTES - 1);

    sd_state_e           r_state, w_state_next;
    logic [31:0]         r_lba, w_lba_next;
    logic                r_oor, w_oor_next;
    logic [SD_IDX_W-1:0] r_idx, w_idx_next;
    logic [LAT_W-1:0]    r_lat, w_lat_next;
    logic                r_gap, w_gap_next;
    logic                r_issued, w_issued_next;
    logic [7:0]          r_data, w_data_next;
    logic                w_step;
    logic [MEM_AW-1:0]   w_mem_addr;

    assign w_mem_addr = MEM_BASE + MEM_AW'({r_lba, {SD_IDX_W{1'b0}}}) + MEM_AW'(r_idx);

    // State and datapath registers, cleared asynchronously.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= StIdle;
            r_lba    <= '0;
            r_oor    <= 1'b0;
            r_idx    <= '0;
            r_lat    <= '0;
            r_gap    <= 1'b0;
            r_issued <= 1'b0;
            r_data   <= '0;
        end else begin
            r_state  <= w_state_next;
            r_lba    <= w_lba_next;
            r_oor    <= w_oor_next;
            r_idx    <= w_idx_next;
            r_lat    <= w_lat_next;
            r_gap    <= w_gap_next;
            r_issued <= w_issued_next;
            r_data   <= w_data_next;
        end
    end

    // Next-state, byte stepping and bus outputs decoded from the current state.
    always_comb begin
        w_state_next     = r_state;
        w_lba_next       = r_lba;
        w_oor_next       = r_oor;
        w_idx_next       = r_idx;
        w_lat_next       = r_lat;
        w_gap_next       = r_gap;
        w_issued_next    = r_issued;
        w_data_next      = r_data;
        w_step           = 1'b0;
        bus.sd_ack       = 1'b0;
        bus.sd_buff_addr = r_idx;
        bus.sd_buff_wr   = 1'b0;
        bus.sd_buff_dout = '0;
        bus.mem_addr     = '0;
        bus.mem_rd       = 1'b0;
        bus.mem_wr       = 1'b0;
        bus.mem_wdata    = '0;

        unique case (r_state)
            StIdle: begin
                // Write wins when both requests are up.
                if (bus.sd_wr || bus.sd_rd) begin
                    w_lba_next   = bus.sd_lba;
                    w_oor_next   = (bus.sd_lba >= bus.img_blocks);
                    w_idx_next   = '0;
                    w_state_next = bus.sd_wr ? StWrAddr : StRdReq;
                end
            end
            StRdReq: begin
                bus.sd_ack   = 1'b1;
                bus.mem_addr = w_mem_addr;
                if (r_oor) begin
                    w_data_next  = '0;
                    w_state_next = StRdPut;
                end else begin
                    bus.mem_rd   = 1'b1;
                    w_state_next = StRdWait;
                end
            end
            StRdWait: begin
                bus.sd_ack   = 1'b1;
                bus.mem_addr = w_mem_addr;
                if (bus.mem_ready) begin
                    w_data_next  = bus.mem_rdata;
                    w_state_next = StRdPut;
                end
            end
            StRdPut: begin
                bus.sd_ack       = 1'b1;
                bus.sd_buff_wr   = 1'b1;
                bus.sd_buff_dout = r_data;
                w_step           = 1'b1;
            end
            StWrAddr: begin
                bus.sd_ack   = 1'b1;
                w_lat_next   = '0;
                w_state_next = StWrGet;
            end
            StWrGet: begin
                bus.sd_ack = 1'b1;
                if (r_lat == LAT_LAST) begin
                    w_data_next   = bus.sd_buff_din;
                    w_issued_next = 1'b0;
                    w_state_next  = StWrReq;
                end else begin
                    w_lat_next = r_lat + 1'b1;
                end
            end
            StWrReq: begin
                bus.sd_ack    = 1'b1;
                bus.mem_addr  = w_mem_addr;
                bus.mem_wdata = r_data;
                // Strobe once, then hold until the memory accepts.
                if (r_oor) begin
                    w_step = 1'b1;
                end else if (!r_issued) begin
                    bus.mem_wr    = 1'b1;
                    w_issued_next = 1'b1;
                end else if (bus.mem_ready) begin
                    w_step = 1'b1;
                end
            end
            StDone: begin
                w_gap_next   = 1'b0;
                w_state_next = StGap;
            end
            StGap: begin
                if (r_gap) begin
                    w_state_next = StIdle;
                end else begin
                    w_gap_next = 1'b1;
                end
            end
            default: w_state_next = StIdle;
        endcase

        if (w_step) begin
            if (r_idx == IDX_LAST) begin
                w_idx_next   = '0;
                w_state_next = StDone;
            end else begin
                w_idx_next   = r_idx + 1'b1;
                w_state_next = (r_state == StRdPut) ? StRdReq : StWrAddr;
            end
        end
    end

endmodule
